// File: rtl/cory_drop.sv
// Packet-aware drop filter: the head beat decides pass or drop for the whole packet.
// Passed beats go through a 2-entry output FIFO; dropped packets are counted.
module cory_drop #(
  parameter int unsigned N = 8,
  parameter int unsigned C = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_a_v,
  input  logic [N-1:0] i_a_d,
  input  logic         i_a_last,
  output logic         o_a_r,
  input  logic         i_a_en,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_last,
  input  logic         i_z_r,
  input  logic         i_cnt_clr,
  output logic [C-1:0] o_drop_cnt,
  output logic         o_dropping
);

  typedef enum logic [1:0] {StHead, StPass, StDrop} state_e;

  state_e       state_q, state_d;
  logic [N:0]   mem_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   occ_q, occ_d;
  logic [C-1:0] cnt_q, cnt_d;

  logic full, empty, drop_beat, a_xfer, z_xfer, push, drop_inc;

  assign full  = (occ_q == 2'd2);
  assign empty = (occ_q == 2'd0);

  // A beat that will be discarded never needs FIFO space, so it is always accepted.
  assign drop_beat = (state_q == StDrop) || ((state_q == StHead) && i_a_v && !i_a_en);
  assign o_a_r     = !reset && (drop_beat || !full);
  assign a_xfer    = i_a_v && o_a_r;
  assign z_xfer    = o_z_v && i_z_r;
  assign push      = a_xfer && !drop_beat;
  assign drop_inc  = a_xfer && (state_q == StHead) && !i_a_en;

  assign o_z_v      = !empty;
  assign o_z_d      = empty ? '0 : mem_q[rd_ptr_q][N-1:0];
  assign o_z_last   = empty ? 1'b0 : mem_q[rd_ptr_q][N];
  assign o_drop_cnt = cnt_q;
  assign o_dropping = (state_q == StDrop);

  always_comb begin
    state_d = state_q;
    if (a_xfer) begin
      unique case (state_q)
        StHead: begin
          if (!i_a_last) state_d = i_a_en ? StPass : StDrop;
        end
        StPass, StDrop: begin
          if (i_a_last) state_d = StHead;
        end
        default: state_d = StHead;
      endcase
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, z_xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Clear wins over the old value, but an increment in the same cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = drop_inc ? {{(C-1){1'b0}}, 1'b1} : '0;
    end else if (drop_inc && (cnt_q != {C{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StHead;
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {i_a_last, i_a_d};
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (z_xfer) rd_ptr_q <= !rd_ptr_q;
    end
  end

endmodule

// File: doc/cory_drop.md
CORY_DROP -- requirements
Module: cory_drop

Interface
REQ-001 Parameter N, default 8: data width in bits.
REQ-002 Parameter C, default 16: width in bits of the dropped-packet counter.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_a_v  input  1  upstream valid.
REQ-006 i_a_d  input  N  upstream data.
REQ-007 i_a_last  input  1  upstream last beat of packet.
REQ-008 o_a_r  output  1  upstream ready.
REQ-009 i_a_en  input  1  1 = pass the packet, 0 = drop it; sampled only on the head beat.
REQ-010 o_z_v  output  1  downstream valid.
REQ-011 o_z_d  output  N  downstream data.
REQ-012 o_z_last  output  1  downstream last.
REQ-013 i_z_r  input  1  downstream ready.
REQ-014 i_cnt_clr  input  1  synchronous clear of o_drop_cnt.
REQ-015 o_drop_cnt  output  C  count of dropped packets.
REQ-016 o_dropping  output  1  registered; 1 while in DROP state.

Function
REQ-017 The block SHALL be packet-aware and SHALL never pass a partial packet: the pass/drop decision is made on the head beat and held through i_a_last.
REQ-018 A transfer SHALL occur on a side when valid and ready are both 1 at a rising clk edge.
REQ-019 The block SHALL implement states HEAD, PASS and DROP, with HEAD as the reset state.
REQ-020 HEAD with i_a_v=1 and i_a_en=1: o_a_r = buffer not full; on transfer the beat is buffered; next state is PASS if i_a_last=0, otherwise HEAD.
REQ-021 HEAD with i_a_v=1 and i_a_en=0: o_a_r=1; the beat is discarded; o_drop_cnt increments by 1; next state is DROP if i_a_last=0, otherwise HEAD.
REQ-022 HEAD with i_a_v=0: o_a_r = buffer not full; no state change.
REQ-023 PASS: o_a_r = buffer not full; i_a_en is ignored; a transfer with i_a_last=1 returns the state to HEAD.
REQ-024 DROP: o_a_r=1; beats are discarded; i_a_en is ignored; a transfer with i_a_last=1 returns the state to HEAD.
REQ-025 The buffer SHALL be a 2-entry FIFO of {last, data}, with o_z_v = FIFO not empty and o_z_d/o_z_last taken from the FIFO head.
REQ-026 There SHALL be no combinational path from i_z_r to o_a_r; the "full" term SHALL be derived from the registered occupancy.
REQ-027 Latency SHALL be 1 cycle: a beat accepted at edge t is presented on o_z at cycle t+1.
REQ-028 Throughput SHALL be 1 beat per cycle when i_z_r is held at 1.
REQ-029 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged, including when the FIFO is full, in which case o_a_r=0 and no push occurs.
REQ-030 Beat order and data SHALL be preserved exactly; dropped beats SHALL never reach o_z.
REQ-031 o_drop_cnt SHALL saturate at 2^C-1.
REQ-032 i_cnt_clr SHALL set o_drop_cnt to 0, except that a clear coinciding with an increment SHALL set it to 1.
REQ-033 Once o_z_v=1, o_z_v, o_z_d and o_z_last SHALL remain stable until a downstream transfer occurs.
REQ-034 o_dropping SHALL be 1 in the cycle after a head-beat drop with i_a_last=0, and SHALL return to 0 in the cycle after the last dropped beat.

Reset
REQ-035 While reset=1 at a clk edge, the next state SHALL be: state HEAD, FIFO empty, o_z_v=0, o_z_d=0, o_z_last=0, o_drop_cnt=0, o_dropping=0.
REQ-036 o_a_r SHALL be 0 in every cycle in which reset=1.
REQ-037 Reset asserted mid-packet SHALL discard the FIFO contents and packet state, and the first valid beat after reset SHALL be treated as a head beat.

Verification
REQ-038 Pass: en=1, 3-beat packet D=0x11,0x22,0x33 (last on 0x33), i_z_r=1 -> o_z carries 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first acceptance; o_z_last=1 only with 0x33; o_drop_cnt=0.
REQ-039 Mid-packet enable change: en=0 on the head of a 4-beat packet, then en toggled to 1 mid-packet -> o_a_r=1 on all beats; no o_z_v; o_drop_cnt=1; o_dropping=1 for 3 cycles.
REQ-040 Backpressure: i_z_r=0 with 5 beats offered -> exactly 2 beats accepted and o_a_r=0 thereafter; after i_z_r=1, all 5 beats delivered in order with no loss or duplication.
REQ-041 Saturation: C=2, drop 5 single-beat packets -> o_drop_cnt sequence 1,2,3,3,3; clear coinciding with a drop -> o_drop_cnt=1.
REQ-042 Reset mid-packet: reset asserted during PASS with 1 beat buffered -> o_z_v=0 and o_a_r=0 during reset; after reset, the next beat with en=0 and last=1 is dropped and o_drop_cnt=1.
